// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
//
// Two-digit (00..99) BCD up/down counter with parallel load. Every new count
// value is offered to a downstream stage as a two-beat digit stream over a
// valid/ready handshake: ones digit first, then tens digit flagged by out_last.
// The counter never stalls on back-pressure. Changes made while a stream is in
// flight collapse into a single pending flag, so only the latest value is
// sent once the current stream finishes.
//
// Parameters
//   WRAP       1 = modulo-100 wrap (99 <-> 00), 0 = saturate at 99 / 00
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   en         count enable, one step per cycle
//   up         direction, 1 = increment, 0 = decrement
//   load       parallel load strobe, overrides en
//   load_val   packed BCD value to load {tens, ones}
//   count      current packed BCD count (registered)
//   tc         terminal count (combinational)
//   load_err   one-cycle pulse after a rejected load (registered)
//   out_valid  digit stream valid
//   out_ready  downstream accepts the current digit
//   out_digit  BCD digit being streamed
//   out_last   high while the tens digit is offered
// -----------------------------------------------------------------------------
module bcd_digit_counter #(
  parameter bit WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       tc,
  output logic       load_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_last
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND_ONES = 2'd1,
    S_SEND_TENS = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Counter datapath
  // ---------------------------------------------------------------------------
  logic [7:0] count_q, count_d;
  logic       load_err_q, load_err_d;

  logic [3:0] ones_q, tens_q;
  logic [3:0] ones_inc, ones_dec, tens_inc, tens_dec;
  logic       load_ok;
  logic       at_max, at_min;
  logic       chg;

  assign ones_q   = count_q[3:0];
  assign tens_q   = count_q[7:4];
  assign ones_inc = ones_q + 4'd1;
  assign ones_dec = ones_q - 4'd1;
  assign tens_inc = tens_q + 4'd1;
  assign tens_dec = tens_q - 4'd1;

  assign load_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  assign at_max   = (count_q == 8'h99);
  assign at_min   = (count_q == 8'h00);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    count_d    = count_q;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          count_d = WRAP ? 8'h00 : 8'h99;
        end else if (ones_q == 4'd9) begin
          count_d = {tens_inc, 4'd0};
        end else begin
          count_d = {tens_q, ones_inc};
        end
      end else begin
        if (at_min) begin
          count_d = WRAP ? 8'h99 : 8'h00;
        end else if (ones_q == 4'd0) begin
          count_d = {tens_dec, 4'd9};
        end else begin
          count_d = {tens_q, ones_dec};
        end
      end
    end
  end

  // Same-value loads, saturated holds and rejected loads all leave count_d
  // equal to count_q, so a plain compare covers every "no change" case.
  assign chg = (count_d != count_q);

  // Terminal count is about the attempted step, not its outcome, so it does
  // not depend on WRAP.
  assign tc = en && !load && ((up && at_max) || (!up && at_min));

  // ---------------------------------------------------------------------------
  // Digit stream
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] snap_q, snap_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | chg;
    snap_d    = snap_q;
    out_valid = 1'b0;
    out_digit = 4'd0;
    out_last  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The snapshot is the pre-edge count; a change landing on this same
        // edge stays pending and triggers the next stream.
        pending_d = chg;
        if (pending_q) begin
          state_d = S_SEND_ONES;
          snap_d  = count_q;
        end
      end
      S_SEND_ONES: begin
        out_valid = 1'b1;
        out_digit = snap_q[3:0];
        if (out_ready) state_d = S_SEND_TENS;
      end
      S_SEND_TENS: begin
        out_valid = 1'b1;
        out_digit = snap_q[7:4];
        out_last  = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it only takes effect on a rising edge, and
    // it aborts any stream in flight by returning the FSM to IDLE.
    if (!rst_n) begin
      count_q    <= 8'h00;
      load_err_q <= 1'b0;
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      snap_q     <= 8'h00;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      snap_q     <= snap_d;
    end
  end

  assign count    = count_q;
  assign load_err = load_err_q;

endmodule
